// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game flow sequencer and its sibling play-field blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: state encoding (IDLE/PLAY/OVER) and the widths of the lives
// register and the two frame counters.
package game_flow_ctrl_pkg;

    localparam int LIVES_W = 3;
    localparam int BLINK_W = 8;
    localparam int HOLD_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    // Lives reload value at the register width.
    function automatic logic [LIVES_W-1:0] lives_init(input int n);
        return LIVES_W'(n);
    endfunction

endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// Frame-tick counter with synchronous clear and terminal-count flag.
// Latency: tc_o reflects the registered count (one cycle after the counting tick).
// Backpressure: none; every qualified tick is counted.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (count -> 0)
//   clear_i     - synchronous clear, has priority over tick_i
//   tick_i      - count enable (already qualified by the parent)
//   tc_o        - count equals TERM
// SAT=1: the count holds at TERM. SAT=0: a tick at TERM wraps the count to 0.
module frame_timer #(
    parameter int W    = 8,
    parameter int TERM = 1,
    parameter bit SAT  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic tick_i,
    output logic tc_o
);

    localparam logic [W-1:0] TERM_C = W'(TERM);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == TERM_C);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (tc_o) begin
                cnt_d = SAT ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-state sequencer: lives tracking, IDLE/PLAY/OVER flow, GAME OVER overlay blink.
// Latency: all outputs registered; an input sampled at edge N shows after edge N.
// Backpressure: none; miss/bomb/frame_tick are single-cycle pulses consumed as they arrive.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   frame_tick   - one pulse per video frame
//   start        - debounced start button level (acted on at its rising edge)
//   miss, bomb   - play-field event pulses
//   play_en      - high only in PLAY
//   over_en      - GAME OVER overlay enable (blinks, then steady)
//   lives        - remaining lives
//   state        - IDLE=0, PLAY=1, OVER=2
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int LIVES        = 3,
    parameter int BLINK_FRAMES = 30,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               miss,
    input  logic               bomb,
    output logic               play_en,
    output logic               over_en,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         state
);

    localparam logic [LIVES_W-1:0] LIVES_C = lives_init(LIVES);
    localparam logic [LIVES_W-1:0] ONE_C   = LIVES_W'(1);

    state_e             state_q;
    logic               play_en_q;
    logic               over_en_q;
    logic [LIVES_W-1:0] lives_q;
    // Resets to 1 so a button held through reset does not look like an edge.
    logic               start_q;

    logic start_edge;
    logic in_over;
    logic hold_done;
    logic blink_tc;
    logic restart;
    logic blink_toggle;

    assign start_edge = start & ~start_q;
    assign in_over    = (state_q == ST_OVER);
    assign restart    = in_over & hold_done & start_edge;

    // Blinking freezes once the hold window has elapsed; over_en is then held at 1.
    assign blink_toggle = frame_tick & in_over & ~hold_done & blink_tc;

    // Both timers sit at zero outside OVER, so OVER is always entered with
    // fresh counts. A tick in the restart cycle is masked so it cannot leak
    // into the next game's counters.
    frame_timer #(
        .W    (BLINK_W),
        .TERM (BLINK_FRAMES - 1),
        .SAT  (1'b0)
    ) u_blink_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (~in_over),
        .tick_i  (frame_tick & in_over & ~hold_done),
        .tc_o    (blink_tc)
    );

    frame_timer #(
        .W    (HOLD_W),
        .TERM (HOLD_FRAMES),
        .SAT  (1'b1)
    ) u_hold_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (~in_over),
        .tick_i  (frame_tick & in_over & ~restart),
        .tc_o    (hold_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            play_en_q <= 1'b0;
            over_en_q <= 1'b0;
            lives_q   <= LIVES_C;
            start_q   <= 1'b1;
        end else begin
            start_q <= start;
            case (state_q)
                ST_IDLE: begin
                    lives_q <= LIVES_C;
                    if (start_edge) begin
                        state_q   <= ST_PLAY;
                        play_en_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // Bomb takes priority so a coincident miss never decrements first.
                    if (bomb || (miss && (lives_q <= ONE_C))) begin
                        lives_q   <= '0;
                        state_q   <= ST_OVER;
                        play_en_q <= 1'b0;
                        over_en_q <= 1'b1;
                    end else if (miss) begin
                        lives_q <= lives_q - ONE_C;
                    end
                end
                ST_OVER: begin
                    if (restart) begin
                        state_q   <= ST_PLAY;
                        play_en_q <= 1'b1;
                        over_en_q <= 1'b0;
                        lives_q   <= LIVES_C;
                    end else if (hold_done) begin
                        over_en_q <= 1'b1;
                    end else if (blink_toggle) begin
                        over_en_q <= ~over_en_q;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    play_en_q <= 1'b0;
                    over_en_q <= 1'b0;
                    lives_q   <= LIVES_C;
                end
            endcase
        end
    end

    assign play_en = play_en_q;
    assign over_en = over_en_q;
    assign lives   = lives_q;
    assign state   = state_q;

endmodule
